// File: rtl/multiplier_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per clock.
// Start/busy/done handshake; the product is registered and held between operations.
// Optional build macro EARLY_TERM_EN: finish as soon as no multiplier bits remain set.
module multiplier_seq #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] m,
  output logic               rout
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] m_q, m_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] sum;
  logic               last;

  // Accumulator plus the current partial product; 2W bits always suffice.
  assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef EARLY_TERM_EN
  // Stop once the bits still to be shifted in are all zero.
  assign last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Next-state, datapath update and termination.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, b};
          mplier_d = a;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          m_d     = sum;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      m_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign m    = m_q;
  assign rout = m_q[2*WIDTH-1];

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed + random bench for multiplier_seq with a queue-based scoreboard.
module tb_multiplier_seq;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] m;
  logic           rout;

  exp_t           q[$];
  int             vectors;
  int             miscompares;
  int             cyc;
  int             acc_cyc;
  logic [2*W-1:0] last_m;

  multiplier_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .m    (m),
    .rout (rout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(logic [W-1:0] x);
    int l;
`ifdef EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < W; i++) if (x[i]) l = i + 1;
`else
    l = W;
`endif
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive start for one edge (only called while idle) and record the expectation.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start   = 1'b0;
    acc_cyc = cyc;
    e.prod  = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    e.lat   = exp_lat(av);
    q.push_back(e);
  endtask

  // Wait (bounded) for done, then pop and compare latency, product and flags.
  task automatic wait_done(input string tag);
    exp_t e;
    while (done !== 1'b1 && (cyc - acc_cyc) < 64) tick();
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 64'(q.size()), 64'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
    chk({tag, "_m"}, 64'(m), 64'(e.prod));
    chk({tag, "_rout"}, 64'(rout), 64'(e.prod[2*W-1]));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    last_m = e.prod;
  endtask

  initial begin
    int k;
    int r;
    logic seen;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    acc_cyc     = 0;
    last_m      = '0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset values, then idle with start low.
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_rout", 64'(rout), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_m", 64'(m), 64'd0);

    // Basic product, busy during run, single-cycle done.
    accept(16'd3, 16'd5);
    chk("t2_busy", 64'(busy), 64'd1);
    wait_done("t2");
    tick();
    chk("t2_pulse", 64'(done), 64'd0);

    // All-ones operands.
    accept(16'hFFFF, 16'hFFFF);
    wait_done("t3");
    chk("t3_const", 64'(m), 64'h0000_0000_FFFE_0001);
    tick();

    // Start while busy is ignored; start during done cycle is accepted.
    accept(16'd2, 16'd7);
    k = (exp_lat(16'd2) > 5) ? 5 : exp_lat(16'd2) - 1;
    repeat (k - 1) tick();
    start = 1'b1;
    a     = 16'd9;
    b     = 16'd9;
    tick();
    start = 1'b0;
    chk("t4_ign_busy", 64'(busy), 64'd1);
    chk("t4_held_m", 64'(m), 64'(last_m));
    wait_done("t4a");
    accept(16'd4, 16'd4);
    chk("t4_b2b_busy", 64'(busy), 64'd1);
    chk("t4_b2b_done", 64'(done), 64'd0);
    wait_done("t4b");

    // Asynchronous reset mid-operation discards it.
    tick();
    accept(16'd100, 16'd200);
    r = (exp_lat(16'd100) > 8) ? 8 : 3;
    repeat (r - 1) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_m", 64'(m), 64'd0);
    chk("t5_rout", 64'(rout), 64'd0);
    q.delete();
    #2;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("t5_nodone", 64'(seen), 64'd0);
    accept(16'd100, 16'd200);
    wait_done("t5");
    tick();

    // Latency corners (early termination dependent).
    accept(16'd1, 16'd9);
    wait_done("t6a");
    tick();
    accept(16'd0, 16'd1234);
    wait_done("t6b");
    tick();
    accept(16'h8000, 16'd3);
    wait_done("t6c");
    tick();
    accept(16'hFFFF, 16'd0);
    wait_done("t6d");

    // Random pairs, issued back-to-back in the done cycle.
    for (int i = 0; i < 150; i++) begin
      accept(W'($urandom), W'($urandom));
      wait_done("rnd");
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
